// File: rtl/fir_filter_param.sv
// Pipelined streaming FIR with shadow/active coefficient banks, rounding, scaling and saturation.
// Latency $clog2(TAPS)+3 with one result per accepted sample; there is no backpressure and the pipeline advances every cycle.
module fir_filter_param #(
  parameter int TAPS      = 16,
  parameter int DIN_W     = 16,
  parameter int COEF_W    = 16,
  parameter int DOUT_W    = 24,
  parameter int OUT_SHIFT = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic [DIN_W-1:0]           din,
  input  logic                       din_valid,
  input  logic                       coef_we,
  input  logic [$clog2(TAPS)-1:0]    coef_addr,
  input  logic [COEF_W-1:0]          coef_wdata,
  input  logic                       coef_commit,
  output logic [DOUT_W-1:0]          dout,
  output logic                       dout_valid,
  output logic                       dout_sat
);

  localparam int S       = $clog2(TAPS);
  localparam int P       = 1 << S;
  localparam int PW      = DIN_W + COEF_W;
  localparam int ACC_W   = PW + S;
  localparam int LATENCY = S + 3;

  // Arrays are padded to P entries; entries at TAPS and above stay zero.
  logic signed [DIN_W-1:0]  dl         [P];
  logic signed [COEF_W-1:0] shadow     [P];
  logic signed [COEF_W-1:0] shadow_nxt [P];
  logic signed [COEF_W-1:0] cact       [P];
  logic signed [PW-1:0]     prod       [P];
  logic [LATENCY-2:0]       vtok;

  always_comb begin
    shadow_nxt = shadow;
    if (coef_we && (int'(coef_addr) < TAPS))
      shadow_nxt[coef_addr] = coef_wdata;
  end

  // Commit copies the post-write shadow so a same-cycle write is included.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < P; i++) begin
        shadow[i] <= (i == 0) ? COEF_W'(1) : '0;
        cact[i]   <= (i == 0) ? COEF_W'(1) : '0;
      end
    end else begin
      shadow <= shadow_nxt;
      if (coef_commit)
        cact <= shadow_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dl   <= '{default: '0};
      vtok <= '0;
    end else if (clear) begin
      dl   <= '{default: '0};
      vtok <= '0;
    end else begin
      vtok <= {vtok[LATENCY-3:0], din_valid};
      if (din_valid) begin
        dl[0] <= din;
        for (int i = 1; i < TAPS; i++)
          dl[i] <= dl[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      prod <= '{default: '0};
    else
      for (int i = 0; i < P; i++)
        prod[i] <= PW'(dl[i]) * PW'(cact[i]);
  end

  // Adder tree: one level per stage, each level one bit wider than the last.
  for (genvar l = 1; l <= S; l++) begin : g_lvl
    localparam int N = P >> l;
    localparam int W = PW + l;
    logic signed [W-1:0] sum [N];
    if (l == 1) begin : g_src
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          sum <= '{default: '0};
        else
          for (int i = 0; i < N; i++)
            sum[i] <= {prod[2*i][PW-1], prod[2*i]} + {prod[2*i+1][PW-1], prod[2*i+1]};
      end
    end else begin : g_src
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          sum <= '{default: '0};
        else
          for (int i = 0; i < N; i++)
            sum[i] <= {g_lvl[l-1].sum[2*i][W-2], g_lvl[l-1].sum[2*i]}
                    + {g_lvl[l-1].sum[2*i+1][W-2], g_lvl[l-1].sum[2*i+1]};
      end
    end
  end

  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W:0]    r;
  logic signed [DOUT_W-1:0] dnext;
  logic                     snext;

  assign acc = g_lvl[S].sum[0];

  if (OUT_SHIFT > 0) begin : g_rnd
    localparam logic signed [ACC_W:0] HALF = (ACC_W+1)'(1) << (OUT_SHIFT - 1);
    assign r = ((ACC_W+1)'(acc) + HALF) >>> OUT_SHIFT;
  end else begin : g_rnd
    assign r = (ACC_W+1)'(acc);
  end

  if (DOUT_W <= ACC_W) begin : g_sat
    localparam logic signed [ACC_W:0] MAXV = {{(ACC_W+2-DOUT_W){1'b0}}, {(DOUT_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] MINV = ~MAXV;
    always_comb begin
      dnext = r[DOUT_W-1:0];
      snext = 1'b0;
      if (r > MAXV) begin
        dnext = MAXV[DOUT_W-1:0];
        snext = 1'b1;
      end else if (r < MINV) begin
        dnext = MINV[DOUT_W-1:0];
        snext = 1'b1;
      end
    end
  end else begin : g_sat
    assign dnext = DOUT_W'(r);
    assign snext = 1'b0;
  end

  // dout/dout_sat only load with a valid token, so they hold across gaps and clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_sat   <= 1'b0;
    end else if (clear) begin
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= vtok[LATENCY-2];
      if (vtok[LATENCY-2]) begin
        dout     <= dnext;
        dout_sat <= snext;
      end
    end
  end

endmodule
